// File: rtl/pipe_ctrl_pkg.sv
// Shared types and bank indices for the pipeline sequencer.
package pipe_ctrl_pkg;

  // RUN: normal sequencing. REDIRECT: a taken branch is waiting for an
  // outstanding fetch to drain before the PC can be steered.
  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } pipe_ctrl_state_t;

  // Bit positions of the pipeline banks in load_regs / flush_regs.
  localparam int IF_ID     = 0;
  localparam int ID_EX     = 1;
  localparam int EX_MEM    = 2;
  localparam int MEM_WB    = 3;
  localparam int NUM_BANKS = 4;

  // One-hot mask selecting a single bank.
  function automatic logic [NUM_BANKS-1:0] bank_mask(input int bank);
    logic [NUM_BANKS-1:0] m;
    m = '0;
    m[bank] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_reg.sv
// Parameterized load-enable register with synchronous clear.
module pipe_ctrl_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Capture d_i when loaded; reset clears the stored value.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-cycle load/hold/bubble decisions for the four
// pipeline banks and the PC, with a deferred redirect when a taken branch
// collides with an outstanding instruction fetch.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 load_use,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic                 load_pc,
  output logic                 pc_sel,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [NUM_BANKS-1:0] load_regs,
  output logic [NUM_BANKS-1:0] flush_regs,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  pipe_ctrl_state_t state_q, state_d;
  logic [PC_WIDTH-1:0]  saved_target;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic d_stall, i_stall;
  logic capture_target;
  logic stall_inc, flush_inc;

  assign d_stall = dmem_req & ~dmem_resp;
  assign i_stall = imem_read & ~imem_resp;

  // Branch target held while the redirect waits for the fetch to finish.
  pipe_ctrl_reg #(
    .WIDTH(PC_WIDTH)
  ) u_saved_target (
    .clk   (clk),
    .reset (reset),
    .load_i(capture_target),
    .d_i   (branch_target),
    .q_o   (saved_target)
  );

  // State register; reset always returns to RUN, dropping any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter REDIRECT on a branch blocked by a fetch, leave once
  // neither memory is stalling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!d_stall && branch_taken && i_stall) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (!d_stall && !i_stall) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode; the priority chain picks exactly one action per cycle,
  // so each counter steps at most once.
  always_comb begin
    load_regs      = '1;
    flush_regs     = '0;
    load_pc        = 1'b1;
    pc_sel         = 1'b0;
    redirect_pc    = branch_target;
    capture_target = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (reset) begin
      load_regs  = '0;
      flush_regs = '1;
      load_pc    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (d_stall) begin
            // Branch in EX/MEM is frozen too, so it is acted on later.
            load_regs = '0;
            load_pc   = 1'b0;
            stall_inc = 1'b1;
          end else if (branch_taken && i_stall) begin
            load_regs      = bank_mask(MEM_WB);
            flush_regs     = bank_mask(IF_ID) | bank_mask(ID_EX) | bank_mask(EX_MEM);
            load_pc        = 1'b0;
            capture_target = 1'b1;
            flush_inc      = 1'b1;
          end else if (branch_taken) begin
            load_regs  = bank_mask(MEM_WB);
            flush_regs = bank_mask(IF_ID) | bank_mask(ID_EX) | bank_mask(EX_MEM);
            pc_sel     = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            // Hold IF_ID and the PC, inject a bubble into ID_EX.
            load_regs  = bank_mask(EX_MEM) | bank_mask(MEM_WB);
            flush_regs = bank_mask(ID_EX);
            load_pc    = 1'b0;
            flush_inc  = 1'b1;
          end else if (i_stall) begin
            load_regs  = ~bank_mask(IF_ID);
            flush_regs = bank_mask(IF_ID);
            load_pc    = 1'b0;
            stall_inc  = 1'b1;
          end
        end
        REDIRECT: begin
          redirect_pc = saved_target;
          if (d_stall) begin
            load_regs = '0;
            load_pc   = 1'b0;
            stall_inc = 1'b1;
          end else if (i_stall) begin
            load_regs  = ~bank_mask(IF_ID);
            flush_regs = bank_mask(IF_ID);
            load_pc    = 1'b0;
            stall_inc  = 1'b1;
          end else begin
            // Fetch done: steer the PC and discard the stale fetched word.
            load_regs  = ~bank_mask(IF_ID);
            flush_regs = bank_mask(IF_ID);
            pc_sel     = 1'b1;
          end
        end
        default: begin
          load_regs = '0;
          load_pc   = 1'b0;
        end
      endcase
    end
  end

  // Counter next values; both wrap naturally at the counter width.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc) stall_d = stall_q + CNT_WIDTH'(1);
    if (flush_inc) flush_d = flush_q + CNT_WIDTH'(1);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the pipeline register banks IF_ID, ID_EX, EX_MEM and MEM_WB, and for the PC register.
- Each cycle it decides, for every bank, whether the bank loads, holds, or is cleared to a bubble through the register's synchronous reset input.
- Decisions come from memory stalls, load-use hazards and taken branches resolved at EX/MEM.
- Holds a pending branch target when a redirect collides with an in-flight instruction fetch.

Parameters:
- PC_WIDTH, 16, width of the PC and branch target.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_read  in  1  IF stage has an instruction fetch outstanding
- imem_resp  in  1  instruction memory completes this cycle
- dmem_req  in  1  MEM stage has a data access outstanding
- dmem_resp  in  1  data memory completes this cycle
- load_use  in  1  ID instruction depends on a load in EX
- branch_taken  in  1  EX/MEM holds a taken branch or jump
- branch_target  in  PC_WIDTH  target address for branch_taken
- load_pc  out  1  PC register load
- pc_sel  out  1  1 = PC mux selects redirect_pc
- redirect_pc  out  PC_WIDTH  redirect address
- load_regs  out  4  load enables; bit0 = IF_ID … bit3 = MEM_WB
- flush_regs  out  4  bubble clear for each bank; drives the register reset input, ORed with the global reset outside this block
- stall_cycles  out  CNT_WIDTH  count of stall cycles
- flush_count  out  CNT_WIDTH  count of bubbles inserted

Behaviour:
- Definitions:
  - d_stall = dmem_req & ~dmem_resp
  - i_stall = imem_read & ~imem_resp
- Outputs are combinational from state, inputs and saved_target. State, saved_target and counters are registered.
- Reset cycle:
  - load_regs = 0, flush_regs = 4'b1111, load_pc = 0, pc_sel = 0.
  - Next state RUN; saved_target and both counters cleared to 0.
  - Reset in REDIRECT discards the pending target.
- Default (RUN, no events): load_regs = 4'b1111, flush_regs = 0, load_pc = 1, pc_sel = 0, redirect_pc = branch_target.
- State RUN, priority high to low:
  - d_stall: full freeze. load_regs = 0, flush_regs = 0, load_pc = 0. branch_taken is ignored because the branch remains in EX/MEM. stall_cycles +1.
  - branch_taken & i_stall: flush_regs = 4'b0111, load_regs[3] = 1, load_pc = 0. saved_target <= branch_target. Next state REDIRECT. flush_count +1.
  - branch_taken: load_pc = 1, pc_sel = 1, redirect_pc = branch_target, flush_regs = 4'b0111, load_regs[3] = 1. flush_count +1.
  - load_use: load_pc = 0, load_regs[0] = 0 (hold IF_ID), flush_regs[1] = 1, load_regs[3:2] = 1. flush_count +1. This applies even if i_stall is also asserted.
  - i_stall: load_pc = 0, flush_regs[0] = 1, load_regs[3:1] = 1. stall_cycles +1.
- State REDIRECT:
  - redirect_pc = saved_target in every sub-case.
  - d_stall: full freeze as in RUN. Stay in REDIRECT. stall_cycles +1.
  - i_stall: load_pc = 0, flush_regs[0] = 1, load_regs[3:1] = 1. Stay in REDIRECT. stall_cycles +1.
  - Otherwise (fetch completed or idle): load_pc = 1, pc_sel = 1, flush_regs[0] = 1 to discard the stale fetched word, load_regs[3:1] = 1. Next state RUN.
  - branch_taken and load_use are ignored, because all younger stages hold bubbles.
- Within one bank, a flush bit overrides its load bit (register semantics).
- Counters wrap at 2^CNT_WIDTH.
- A count is never double-counted in one cycle; the priority above selects exactly one action.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - enum pipe_ctrl_state_t {RUN, REDIRECT}
  - constants IF_ID = 0, ID_EX = 1, EX_MEM = 2, MEM_WB = 3, NUM_BANKS = 4
- saved_target is one instance of the existing parameterized register (width = PC_WIDTH, load = redirect capture).
- No other sub-modules.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0. Required: reset cycles give flush_regs = 4'b1111, load_regs = 0. First cycle after release gives load_regs = 4'b1111, load_pc = 1, counters = 0.
- dmem_req = 1 for 3 cycles, dmem_resp = 1 on the 3rd, branch_taken = 1 throughout. Required: 2 freeze cycles, stall_cycles = 2. Then the branch action on cycle 3 with redirect_pc = target and flush_regs = 4'b0111.
- load_use pulsed 1 cycle. Required: load_regs = 4'b1100, flush_regs = 4'b0010, load_pc = 0, flush_count = 1.
- branch_taken with target 16'h1234 while imem_read = 1 and imem_resp = 0, then imem_resp after 2 more cycles. Required:
  - Cycle 0: flush_regs = 4'b0111, load_pc = 0.
  - Next 2 cycles: flush_regs[0] = 1, load_pc = 0.
  - Response cycle: load_pc = 1, pc_sel = 1, redirect_pc = 16'h1234, then RUN.
- Same as the previous scenario, but reset asserted during REDIRECT. Required: RUN afterwards, with pc_sel = 0 on the first normal cycle.
- imem stall of 4 cycles with no other events. Required: 4 cycles of flush_regs = 4'b0001, load_regs = 4'b1110, load_pc = 0, and stall_cycles = 4.
